// File: rtl/sprite_dispatcher_if.sv
// sprite_dispatcher_if: record handshake between the sprite dispatcher and
// the graphics renderer.
//   sprite_valid        - record on sprite_* is valid (dispatcher -> renderer)
//   sprite_ready        - renderer can accept a record (renderer -> dispatcher)
//   sprite_x/y          - record position
//   sprite_frame_number - spritesheet frame for the record
// A record transfers on any clock edge where sprite_valid && sprite_ready.
interface sprite_dispatcher_if #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int FW = 9
);
  logic          sprite_valid;
  logic          sprite_ready;
  logic [XW-1:0] sprite_x;
  logic [YW-1:0] sprite_y;
  logic [FW-1:0] sprite_frame_number;

  modport master (
    output sprite_valid, sprite_x, sprite_y, sprite_frame_number,
    input  sprite_ready
  );

  modport slave (
    input  sprite_valid, sprite_x, sprite_y, sprite_frame_number,
    output sprite_ready
  );
endinterface

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher: per-frame sprite scheduler upstream of the renderer.
// Holds a table of MAX_SPRITES entities; every change of frame_count starts
// a pass that walks the table in ascending index order and presents each
// active entity as one (x, y, base_frame + anim_phase) record.
// Ports:
//   clk_pixel      - pixel clock, sole clock
//   sys_rst_n      - asynchronous active-low reset
//   frame_count    - video frame counter; any change starts a pass
//   wr_*           - table write port (wr_en strobes entry wr_index)
//   spr            - record handshake (master side)
//   busy           - pass in progress
//   pass_done      - one-cycle pulse when a pass completes
//   overrun        - sticky: frame change arrived while busy
module sprite_dispatcher #(
  parameter int MAX_SPRITES = 16,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720,
  parameter int NUM_FRAMES  = 512,
  parameter int ANIM_LEN    = 8,
  parameter int ANIM_DIV    = 4,
  localparam int IW = $clog2(MAX_SPRITES),
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic                 clk_pixel,
  input  logic                 sys_rst_n,
  input  logic [5:0]           frame_count,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_index,
  input  logic                 wr_active,
  input  logic [XW-1:0]        wr_x,
  input  logic [YW-1:0]        wr_y,
  input  logic [FW-1:0]        wr_base_frame,
  sprite_dispatcher_if.master  spr,
  output logic                 busy,
  output logic                 pass_done,
  output logic                 overrun
);

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int AW = (ANIM_LEN > 1) ? $clog2(ANIM_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] f_q, f_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          pending_q, pending_d;

  logic [MAX_SPRITES-1:0] ent_active;
  logic [XW-1:0]          ent_x    [MAX_SPRITES];
  logic [YW-1:0]          ent_y    [MAX_SPRITES];
  logic [FW-1:0]          ent_base [MAX_SPRITES];

  logic [5:0]    prev_fc;
  logic [DW-1:0] div_q;
  logic [AW-1:0] phase_q;

  logic          new_frame;
  logic          last;
  logic          xfer;
  logic          scan_done;
  logic [FW-1:0] frame_calc;

  assign new_frame  = (frame_count != prev_fc);
  assign last       = (index_q == IW'(MAX_SPRITES - 1));
  assign xfer       = valid_q && spr.sprite_ready;
  assign scan_done  = last && !ent_active[index_q];
  assign frame_calc = FW'((32'(ent_base[index_q]) + 32'(phase_q)) % NUM_FRAMES);

  // Table: only the active flags need clearing; payload is don't-care
  // while an entry is inactive.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ent_active <= '0;
    end else if (wr_en) begin
      ent_active[wr_index] <= wr_active;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      ent_x[wr_index]    <= wr_x;
      ent_y[wr_index]    <= wr_y;
      ent_base[wr_index] <= wr_base_frame;
    end
  end

  // Frame-change detect and animation phase.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_fc <= '0;
      div_q   <= '0;
      phase_q <= '0;
    end else begin
      prev_fc <= frame_count;
      if (new_frame) begin
        if (div_q == DW'(ANIM_DIV - 1)) begin
          div_q   <= '0;
          phase_q <= (phase_q == AW'(ANIM_LEN - 1)) ? '0 : phase_q + 1'b1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      index_q   <= '0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      f_q       <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      f_q       <= f_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    f_d       = f_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    pending_d = pending_q;

    unique case (state_q)
      IDLE: begin
        if (new_frame || pending_q) begin
          state_d   = SCAN;
          index_d   = '0;
          pending_d = 1'b0;
        end
      end

      SCAN: begin
        // Nothing is presented in SCAN, so a frame change can restart the
        // walk immediately; a change on the final inactive slot completes
        // the pass and is carried into the next one via pending.
        if (scan_done) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          pending_d = new_frame;
        end else if (new_frame) begin
          overrun_d = 1'b1;
          index_d   = '0;
        end else if (ent_active[index_q]) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          x_d     = ent_x[index_q];
          y_d     = ent_y[index_q];
          f_d     = frame_calc;
        end else begin
          index_d = index_q + 1'b1;
        end
      end

      PRESENT: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (pending_q || (new_frame && !last)) begin
            state_d   = SCAN;
            index_d   = '0;
            pending_d = 1'b0;
            if (new_frame) overrun_d = 1'b1;
          end else if (last) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            pending_d = new_frame;
          end else begin
            state_d = SCAN;
            index_d = index_q + 1'b1;
          end
        end else if (new_frame) begin
          overrun_d = 1'b1;
          pending_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign spr.sprite_valid        = valid_q;
  assign spr.sprite_x            = x_q;
  assign spr.sprite_y            = y_q;
  assign spr.sprite_frame_number = f_q;
  assign busy      = (state_q != IDLE);
  assign pass_done = done_q;
  assign overrun   = overrun_q;

endmodule
